// File: rtl/dmem_port_arbiter_if.sv
// Data memory arbiter bus: CPU, debug and memory sides.
// slave = arbiter view, master = environment view.
interface dmem_port_arbiter_if #(
  parameter int DADR_W = 14
);
  logic              cpu_req;
  logic              cpu_we;
  logic [DADR_W-1:0] cpu_adr;
  logic [3:0]        cpu_be;
  logic [31:0]       cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [31:0]       cpu_rdata;
  logic              dbg_req;
  logic              dbg_we;
  logic              dbg_lock;
  logic [DADR_W-1:0] dbg_adr;
  logic [31:0]       dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [31:0]       dbg_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [DADR_W-1:0] mem_adr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_be, cpu_wdata,
    input  dbg_req, dbg_we, dbg_lock, dbg_adr, dbg_wdata,
    input  mem_rdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_adr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_be, cpu_wdata,
    output dbg_req, dbg_we, dbg_lock, dbg_adr, dbg_wdata,
    output mem_rdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_adr, mem_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// CPU / debug arbiter for the single-port data memory.
// ARB_PERF_CNT_EN adds the cpu_stall_cnt stall counter.
module dmem_port_arbiter #(
  parameter int DADR_W     = 14,
  parameter int STARVE_MAX = 8
) (
  input logic clk,
  input logic rst,
  dmem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] cpu_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_CPU,
    S_FORCE,
    S_LOCK
  } state_t;

  localparam logic [7:0] STARVE_TOP = 8'(STARVE_MAX - 1);

  state_t            state, state_nx;
  logic [7:0]        starve_cnt, starve_nx;
  logic              cpu_gnt, dbg_gnt;
  logic              cpu_stall;
  logic              rd_pend, rd_dbg;
  logic              cpu_rv, dbg_rv;
  logic [31:0]       cpu_rdata_q, dbg_rdata_q;
  logic [DADR_W-1:0] adr_mux;
  logic [31:0]       wdata_mux;
  logic [3:0]        we_mux;

  // Grant decision, starvation count and next state
  always_comb begin
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    state_nx  = state;
    starve_nx = '0;
    if (!rst) begin
      case (state)
        S_CPU:   dbg_gnt = bus.dbg_req && !bus.cpu_req;
        default: dbg_gnt = bus.dbg_req;
      endcase
      cpu_gnt = bus.cpu_req && !dbg_gnt;
      if (dbg_gnt)
        state_nx = bus.dbg_lock ? S_LOCK : S_CPU;
      else if (state == S_CPU && bus.dbg_req &&
               starve_cnt == STARVE_TOP)
        state_nx = S_FORCE;
      else if (state == S_LOCK && !bus.dbg_lock &&
               !bus.dbg_req)
        state_nx = S_CPU;
      if (bus.dbg_req && !dbg_gnt)
        starve_nx = (starve_cnt == STARVE_TOP) ?
                    starve_cnt : starve_cnt + 8'd1;
    end
  end

  // Memory port mux driven by whichever side holds the grant
  always_comb begin
    we_mux    = 4'h0;
    adr_mux   = '0;
    wdata_mux = '0;
    unique case (1'b1)
      cpu_gnt: begin
        we_mux    = bus.cpu_we ? bus.cpu_be : 4'h0;
        adr_mux   = bus.cpu_adr;
        wdata_mux = bus.cpu_wdata;
      end
      dbg_gnt: begin
        we_mux    = bus.dbg_we ? 4'hF : 4'h0;
        adr_mux   = bus.dbg_adr;
        wdata_mux = bus.dbg_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_stall = !rst && bus.cpu_req && !cpu_gnt;
  assign cpu_rv    = !rst && rd_pend && !rd_dbg;
  assign dbg_rv    = !rst && rd_pend && rd_dbg;

  assign bus.cpu_stall  = cpu_stall;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.mem_en     = cpu_gnt || dbg_gnt;
  assign bus.mem_we     = we_mux;
  assign bus.mem_adr    = adr_mux;
  assign bus.mem_wdata  = wdata_mux;
  assign bus.cpu_rvalid = cpu_rv;
  assign bus.dbg_rvalid = dbg_rv;
  assign bus.cpu_rdata  = cpu_rv ? bus.mem_rdata : cpu_rdata_q;
  assign bus.dbg_rdata  = dbg_rv ? bus.mem_rdata : dbg_rdata_q;

  // State, starvation counter, read-return tag and held rdata
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_CPU;
      starve_cnt  <= '0;
      rd_pend     <= 1'b0;
      rd_dbg      <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
      rd_pend    <= (cpu_gnt && !bus.cpu_we) ||
                    (dbg_gnt && !bus.dbg_we);
      rd_dbg     <= dbg_gnt;
      if (cpu_rv) cpu_rdata_q <= bus.mem_rdata;
      if (dbg_rv) dbg_rdata_q <= bus.mem_rdata;
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Saturating count of CPU stall cycles
  always_ff @(posedge clk) begin
    if (rst)
      cpu_stall_cnt <= '0;
    else if (cpu_stall && cpu_stall_cnt != '1)
      cpu_stall_cnt <= cpu_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter.
// Vector table, directed corner sequences, random vs model.
module tb_dmem_port_arbiter;

  localparam int AW = 14;
  localparam int SMAX = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  dmem_port_arbiter_if #(.DADR_W(AW)) bus ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] cpu_stall_cnt;
`endif

  dmem_port_arbiter #(.DADR_W(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .cpu_stall_cnt(cpu_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // reference model state
  bit          m_pri = 0;
  bit          m_lockm = 0;
  int          m_denied = 0;
  int          m_owner = -1;
  logic [31:0] m_crd = '0;
  logic [31:0] m_drd = '0;
  longint      m_stalls = 0;

  logic e_cg, e_dg, e_stall, e_crv, e_drv;
  logic [3:0] e_we;
  logic [AW-1:0] e_adr;
  logic [31:0] e_wd, e_crd, e_drd;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endfunction

  task automatic idle();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_adr = '0;
    bus.cpu_be = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_lock = 0;
    bus.dbg_adr = '0; bus.dbg_wdata = '0;
    bus.mem_rdata = '0;
  endtask

  // move to mid-cycle, predict outputs from the model, compare
  task automatic settle();
    #4;
    if (rst) begin
      e_dg = 0; e_cg = 0; e_crv = 0; e_drv = 0;
    end else begin
      e_dg = m_pri ? bus.dbg_req : (bus.dbg_req && !bus.cpu_req);
      e_cg = bus.cpu_req && !e_dg;
      e_crv = (m_owner == 0);
      e_drv = (m_owner == 1);
    end
    e_stall = !rst && bus.cpu_req && !e_cg;
    e_we = e_cg ? (bus.cpu_we ? bus.cpu_be : 4'h0) :
           e_dg ? (bus.dbg_we ? 4'hF : 4'h0) : 4'h0;
    e_adr = e_cg ? bus.cpu_adr : e_dg ? bus.dbg_adr : '0;
    e_wd = e_cg ? bus.cpu_wdata : e_dg ? bus.dbg_wdata : '0;
    e_crd = e_crv ? bus.mem_rdata : m_crd;
    e_drd = e_drv ? bus.mem_rdata : m_drd;
    chk("model stall", bus.cpu_stall, e_stall);
    chk("model dbg_gnt", bus.dbg_gnt, e_dg);
    chk("model mem_en", bus.mem_en, e_cg | e_dg);
    chk("model mem_we", bus.mem_we, e_we);
    chk("model mem_adr", bus.mem_adr, e_adr);
    chk("model mem_wdata", bus.mem_wdata, e_wd);
    chk("model cpu_rvalid", bus.cpu_rvalid, e_crv);
    chk("model dbg_rvalid", bus.dbg_rvalid, e_drv);
    chk("model cpu_rdata", bus.cpu_rdata, e_crd);
    chk("model dbg_rdata", bus.dbg_rdata, e_drd);
`ifdef ARB_PERF_CNT_EN
    chk("model stall_cnt", cpu_stall_cnt, 64'(m_stalls));
`endif
  endtask

  // commit the model for this cycle and cross the clock edge
  task automatic adv();
    if (rst) begin
      m_pri = 0; m_lockm = 0; m_denied = 0; m_owner = -1;
      m_crd = '0; m_drd = '0; m_stalls = 0;
    end else begin
      if (e_crv) m_crd = bus.mem_rdata;
      if (e_drv) m_drd = bus.mem_rdata;
      m_owner = (e_cg && !bus.cpu_we) ? 0 :
                (e_dg && !bus.dbg_we) ? 1 : -1;
      if (e_stall) m_stalls++;
      if (e_dg) begin
        m_pri = bus.dbg_lock;
        m_lockm = bus.dbg_lock;
        m_denied = 0;
      end else begin
        if (m_lockm && !bus.dbg_lock && !bus.dbg_req) begin
          m_pri = 0;
          m_lockm = 0;
        end
        if (bus.dbg_req) begin
          m_denied++;
          if (m_denied >= SMAX) m_pri = 1;
        end else begin
          m_denied = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst, creq, cwe;
    logic [AW-1:0] cadr;
    logic [3:0] cbe;
    logic [31:0] cwd;
    logic dreq, dwe, dlk;
    logic [AW-1:0] dadr;
    logic [31:0] dwd, mrd;
    logic stall, gnt, en;
    logic [3:0] we;
    logic [AW-1:0] adr;
    logic [31:0] wd;
    logic crv, drv;
    logic [31:0] crd, drd;
  } vec_t;

  vec_t tv[8];

  initial begin
    bit got;
    int n;
    bit last_dg;

    tv[0] = '{1,1,0,14'h010,4'h0,32'h0, 0,0,0,14'h0,32'h0,
              32'hDEADBEEF,
              0,0,0,4'h0,14'h0,32'h0, 0,0,32'h0,32'h0};
    tv[1] = '{0,1,0,14'h010,4'h0,32'h0, 0,0,0,14'h0,32'h0,
              32'hDEADBEEF,
              0,0,1,4'h0,14'h010,32'h0, 0,0,32'h0,32'h0};
    tv[2] = '{0,0,0,14'h0,4'h0,32'h0,
              1,1,0,14'h020,32'h12345678, 32'hDEADBEEF,
              0,1,1,4'hF,14'h020,32'h12345678,
              1,0,32'hDEADBEEF,32'h0};
    tv[3] = '{0,1,1,14'h033,4'h5,32'hAABBCCDD,
              0,0,0,14'h0,32'h0, 32'h0,
              0,0,1,4'h5,14'h033,32'hAABBCCDD,
              0,0,32'hDEADBEEF,32'h0};
    tv[4] = '{0,0,0,14'h0,4'h0,32'h0, 0,0,0,14'h0,32'h0,
              32'h55,
              0,0,0,4'h0,14'h0,32'h0, 0,0,32'hDEADBEEF,32'h0};
    tv[5] = '{0,1,0,14'h005,4'hF,32'h99,
              1,0,0,14'h007,32'h77, 32'h0,
              0,0,1,4'h0,14'h005,32'h99,
              0,0,32'hDEADBEEF,32'h0};
    tv[6] = '{0,0,0,14'h0,4'h0,32'h0,
              1,0,0,14'h007,32'h77, 32'h11112222,
              0,1,1,4'h0,14'h007,32'h77,
              1,0,32'h11112222,32'h0};
    tv[7] = '{0,0,0,14'h0,4'h0,32'h0, 0,0,0,14'h0,32'h0,
              32'h33334444,
              0,0,0,4'h0,14'h0,32'h0,
              0,1,32'h11112222,32'h33334444};

    idle();
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      rst = tv[i].rst;
      bus.cpu_req = tv[i].creq; bus.cpu_we = tv[i].cwe;
      bus.cpu_adr = tv[i].cadr; bus.cpu_be = tv[i].cbe;
      bus.cpu_wdata = tv[i].cwd;
      bus.dbg_req = tv[i].dreq; bus.dbg_we = tv[i].dwe;
      bus.dbg_lock = tv[i].dlk; bus.dbg_adr = tv[i].dadr;
      bus.dbg_wdata = tv[i].dwd; bus.mem_rdata = tv[i].mrd;
      settle();
      chk($sformatf("v%0d stall", i), bus.cpu_stall, tv[i].stall);
      chk($sformatf("v%0d gnt", i), bus.dbg_gnt, tv[i].gnt);
      chk($sformatf("v%0d en", i), bus.mem_en, tv[i].en);
      chk($sformatf("v%0d we", i), bus.mem_we, tv[i].we);
      chk($sformatf("v%0d adr", i), bus.mem_adr, tv[i].adr);
      chk($sformatf("v%0d wd", i), bus.mem_wdata, tv[i].wd);
      chk($sformatf("v%0d crv", i), bus.cpu_rvalid, tv[i].crv);
      chk($sformatf("v%0d drv", i), bus.dbg_rvalid, tv[i].drv);
      chk($sformatf("v%0d crd", i), bus.cpu_rdata, tv[i].crd);
      chk($sformatf("v%0d drd", i), bus.dbg_rdata, tv[i].drd);
      adv();
    end
    rst = 0;

    // starvation: 8 denials, one forced grant, CPU resumes
    idle();
    bus.cpu_req = 1; bus.cpu_adr = 14'h001;
    bus.dbg_req = 1; bus.dbg_adr = 14'h002;
    for (int i = 1; i <= 10; i++) begin
      settle();
      chk($sformatf("t3 gnt c%0d", i), bus.dbg_gnt, i == 9);
      chk($sformatf("t3 stall c%0d", i), bus.cpu_stall, i == 9);
      if (i == 9) chk("t3 adr dbg", bus.mem_adr, 14'h002);
      if (i == 10) chk("t3 adr cpu", bus.mem_adr, 14'h001);
      adv();
      if (i == 9) bus.dbg_req = 0;
    end

    // locked read burst of four
    rst = 1;
    settle();
    adv();
    rst = 0;
    idle();
    bus.cpu_req = 1; bus.cpu_adr = 14'h001;
    bus.dbg_req = 1; bus.dbg_lock = 1; bus.dbg_adr = 14'h040;
    for (int i = 1; i <= 14; i++) begin
      settle();
      if (i <= 8) chk("t4 denied", bus.dbg_gnt, 0);
      if (i >= 9 && i <= 12) begin
        chk($sformatf("t4 gnt c%0d", i), bus.dbg_gnt, 1);
        chk($sformatf("t4 stall c%0d", i), bus.cpu_stall, 1);
        chk("t4 adr", bus.mem_adr, 14'(14'h040 + i - 9));
      end
      chk($sformatf("t4 drv c%0d", i), bus.dbg_rvalid,
          i >= 10 && i <= 13);
      if (i >= 13) begin
        chk("t4 cpu back", bus.cpu_stall, 0);
        chk("t4 cpu adr", bus.mem_adr, 14'h001);
      end
      adv();
      if (i >= 9 && i < 12) bus.dbg_adr = bus.dbg_adr + 14'd1;
      if (i == 12) begin
        bus.dbg_lock = 0;
        bus.dbg_req = 0;
      end
    end
`ifdef ARB_PERF_CNT_EN
    settle();
    chk("t6 stall_cnt", cpu_stall_cnt, 4);
    adv();
`endif

    // reset in mid-burst with a debug read in flight
    bus.dbg_req = 1; bus.dbg_lock = 1; bus.dbg_adr = 14'h060;
    n = 0;
    got = 0;
    do begin
      settle();
      got = bus.dbg_gnt;
      adv();
      n++;
    end while (!got && n < 20);
    chk("t5 first gnt", got, 1);
    settle();
    chk("t5 locked gnt", bus.dbg_gnt, 1);
    adv();
    rst = 1;
    settle();
    chk("t5 rst drv", bus.dbg_rvalid, 0);
    chk("t5 rst en", bus.mem_en, 0);
    chk("t5 rst stall", bus.cpu_stall, 0);
    adv();
    rst = 0;
    settle();
    chk("t5 post drv", bus.dbg_rvalid, 0);
    chk("t5 post stall", bus.cpu_stall, 0);
    chk("t5 post gnt", bus.dbg_gnt, 0);
`ifdef ARB_PERF_CNT_EN
    chk("t6 cnt clr", cpu_stall_cnt, 0);
`endif
    n = 0;
    got = bus.dbg_gnt;
    adv();
    while (!got && n < 20) begin
      n++;
      settle();
      got = bus.dbg_gnt;
      adv();
    end
    chk("t5 denials", n, SMAX);
    bus.dbg_lock = 0;
    bus.dbg_req = 0;
    settle();
    adv();

    // random traffic against the model
    last_dg = 0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      bus.cpu_req = ($urandom_range(0, 3) != 0);
      bus.cpu_we = $urandom_range(0, 1);
      bus.cpu_adr = 14'($urandom);
      bus.cpu_be = 4'($urandom);
      bus.cpu_wdata = $urandom;
      if (!(bus.dbg_req && !last_dg)) begin
        bus.dbg_req = ($urandom_range(0, 2) != 0);
        bus.dbg_we = $urandom_range(0, 1);
        bus.dbg_adr = 14'($urandom);
        bus.dbg_wdata = $urandom;
      end
      bus.dbg_lock = $urandom_range(0, 1);
      bus.mem_rdata = $urandom;
      settle();
      last_dg = e_dg;
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
